// File: rtl/spi_mem.sv
// Byte-wide request bridge to an FM25L16-style SPI FRAM: each request becomes one
// 32-bit READ/WRITE frame (opcode, addr hi, addr lo, data), SPI mode 0, MSB first.
module spi_mem #(
    parameter int SCK_HALF = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_en,
    input  logic [5:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       valid,
    output logic       spi_clk,
    output logic       spi_cs,
    output logic       spi_so,
    input  logic       spi_si
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCK_HALF - 1);

    state_t          state_q, state_d;
    logic [31:0]     frame_q, frame_d;
    logic [DW-1:0]   div_q, div_d;
    logic [6:0]      half_q, half_d;
    logic [7:0]      cap_q, cap_d;
    logic [7:0]      rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            sclk_q, sclk_d;
    logic            cs_q, cs_d;
    logic            so_q, so_d;
    logic            valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;
        half_d  = half_q;
        cap_d   = cap_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        so_d    = so_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (en && !valid_q) begin
                    wr_d    = wr_en;
                    frame_d = {(wr_en ? 8'h02 : 8'h03), 8'h00, 2'b00, addr,
                               (wr_en ? wr_data : 8'h00)};
                    so_d    = frame_d[31];
                    cs_d    = 1'b0;
                    div_d   = '0;
                    half_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // half_q counts spi_clk half-periods already completed; tick n = half_q+1
                if (div_q == DIV_MAX) begin
                    div_d  = '0;
                    half_d = half_q + 7'd1;
                    if (half_q < 7'd64) begin
                        sclk_d = ~sclk_q;
                        if (!sclk_q) begin
                            if (half_q >= 7'd48)
                                cap_d = {cap_q[6:0], spi_si};
                        end else begin
                            frame_d = {frame_q[30:0], 1'b0};
                            so_d    = (half_q == 7'd63) ? 1'b0 : frame_q[30];
                        end
                    end else begin
                        cs_d    = 1'b1;
                        valid_d = 1'b1;
                        if (!wr_q)
                            rd_d = cap_q;
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                if (!en) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            div_q   <= '0;
            half_q  <= '0;
            cap_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            so_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            div_q   <= div_d;
            half_q  <= half_d;
            cap_q   <= cap_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            so_q    <= so_d;
            valid_q <= valid_d;
        end
    end

    assign rd_data = rd_q;
    assign valid   = valid_q;
    assign spi_clk = sclk_q;
    assign spi_cs  = cs_q;
    assign spi_so  = so_q;

endmodule

// File: tb/tb_spi_mem.sv
// Bench for spi_mem: behavioural FRAM model on the SPI pins, directed vector table,
// reset-mid-frame and handshake sequences, then random write/read-back pairs.
`timescale 1ns/1ps
module tb_spi_mem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       valid;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_so;
    logic       spi_si = 1'b0;

    int checks = 0;
    int failures = 0;

    spi_mem #(.SCK_HALF(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .valid(valid), .spi_clk(spi_clk),
        .spi_cs(spi_cs), .spi_so(spi_so), .spi_si(spi_si)
    );

    always #5 clk = ~clk;

    // FRAM model: shifts MOSI on rising spi_clk, drives MISO after falling edges 24..31
    logic [7:0]  mem [64];
    logic [31:0] dev_sh = '0;
    int          dev_bits = 0;
    logic [7:0]  dev_op = '0;
    logic [5:0]  dev_addr = '0;
    logic [31:0] last_frame = '0;
    int          last_bits = 0;
    int          frames_seen = 0;
    int          glitches = 0;

    always @(spi_clk or spi_cs) begin
        if (spi_cs) begin
            if (dev_bits > 0) begin
                last_frame = dev_sh;
                last_bits  = dev_bits;
            end
            dev_bits = 0;
            dev_sh   = '0;
            spi_si   = 1'b0;
        end else if (spi_clk) begin
            dev_sh   = {dev_sh[30:0], spi_so};
            dev_bits = dev_bits + 1;
            if (dev_bits == 24) begin
                dev_op   = dev_sh[23:16];
                dev_addr = dev_sh[5:0];
            end
            if (dev_bits == 32 && dev_op == 8'h02)
                mem[dev_addr] = dev_sh[7:0];
        end else if (dev_bits >= 24 && dev_bits < 32 && dev_op == 8'h03) begin
            spi_si = mem[dev_addr][31 - dev_bits];
        end
    end

    always @(negedge spi_cs) frames_seen++;
    always @(posedge spi_clk) if (spi_cs) glitches++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    int exp_frames = 0;

    task automatic do_txn(input logic w, input logic [5:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int hold);
        logic [31:0] exp_frame;
        int cyc;
        bit got;
        exp_frame = {(w ? 8'h02 : 8'h03), 8'h00, 2'b00, a, (w ? d : 8'h00)};
        @(posedge clk); #1;
        en = 1'b1; wr_en = w; addr = a; wr_data = d;
        exp_frames++;
        cyc = 0; got = 0;
        while (cyc < 200 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk("cs_low_after_accept", {31'd0, spi_cs}, 32'd0);
                wr_en = ~w; addr = ~a; wr_data = ~d;
            end
            if (valid) got = 1;
        end
        chk("latency", got ? cyc - 1 : 32'hFFFF, 32'd65);
        chk("cs_high_at_valid", {31'd0, spi_cs}, 32'd1);
        chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
        chk("frame", last_frame, exp_frame);
        chk("frame_bits", last_bits, 32'd32);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid_cs", {30'd0, valid, spi_cs}, 32'd3);
        end
        en = 1'b0;
        @(posedge clk); #1;
        chk("valid_drop", {31'd0, valid}, 32'd0);
    endtask

    typedef struct {
        logic       w;
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        int         hold;
    } vec_t;

    vec_t vecs [7];
    logic [7:0] last_rd;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 1);
        mem[6'h15] = 8'h3C;
        vecs[0] = '{1'b1, 6'h2A, 8'hA5, 8'h00, 10};
        vecs[1] = '{1'b0, 6'h15, 8'h77, 8'h3C, 0};
        vecs[2] = '{1'b1, 6'h00, 8'hFF, 8'h3C, 0};
        vecs[3] = '{1'b0, 6'h00, 8'h00, 8'hFF, 0};
        vecs[4] = '{1'b1, 6'h3F, 8'h00, 8'hFF, 3};
        vecs[5] = '{1'b0, 6'h3F, 8'h00, 8'h00, 0};
        vecs[6] = '{1'b0, 6'h2A, 8'h00, 8'hA5, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", {31'd0, spi_cs}, 32'd1);
        chk("rst_clk", {31'd0, spi_clk}, 32'd0);
        chk("rst_so", {31'd0, spi_so}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_rd", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].hold);

        // abort a write to 0x15 after rising edge 10; memory must keep 0x3C
        begin
            int cyc;
            @(posedge clk); #1;
            en = 1'b1; wr_en = 1'b1; addr = 6'h15; wr_data = 8'h99;
            exp_frames++;
            cyc = 0;
            while (cyc < 100 && dev_bits < 10) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("reach_edge10", dev_bits, 32'd10);
            rst_n = 1'b0; en = 1'b0;
            @(posedge clk); #1;
            chk("midrst_cs", {31'd0, spi_cs}, 32'd1);
            chk("midrst_clk", {31'd0, spi_clk}, 32'd0);
            chk("midrst_so", {31'd0, spi_so}, 32'd0);
            chk("midrst_valid", {31'd0, valid}, 32'd0);
            chk("midrst_rd", {24'd0, rd_data}, 32'd0);
            rst_n = 1'b1;
            do_txn(1'b0, 6'h15, 8'h00, 8'h3C, 0);
        end

        last_rd = 8'h3C;
        for (int i = 0; i < 100; i++) begin
            logic [5:0] a;
            logic [7:0] d;
            a = 6'($urandom_range(0, 63));
            d = 8'($urandom_range(0, 255));
            do_txn(1'b1, a, d, last_rd, 0);
            do_txn(1'b0, a, 8'h00, d, 0);
            last_rd = d;
        end

        chk("frame_count", frames_seen, exp_frames);
        chk("sclk_while_cs_high", glitches, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
